// File: rtl/hevc_subpel_fir.sv
// HEVC 8-tap luma sub-pixel interpolation filter with a stall-able output pipeline.
// Define HEVC_FIR_ROUND_EN for round-half-up; otherwise the result is floored.
module hevc_subpel_fir #(
    parameter int BIT_DEPTH      = 8,
    parameter int OUT_REG_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] in_pixel,
    input  logic                 in_sol,
    input  logic [1:0]           in_phase,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_pixel
);

    localparam int SW = BIT_DEPTH + 9;
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << BIT_DEPTH) - 1);

    localparam logic signed [7:0] C1 [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
    localparam logic signed [7:0] C2 [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
    localparam logic signed [7:0] C3 [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

    logic                  advance;
    logic                  accept;
    logic                  issue;
    logic [BIT_DEPTH-1:0]  win_q [8];
    logic [BIT_DEPTH-1:0]  win_d [8];
    logic [3:0]            fill_q;
    logic [3:0]            fill_d;
    logic                  s1_valid_q;
    logic [1:0]            s1_phase_q;
    logic signed [7:0]     coef_w [8];
    logic signed [SW-1:0]  prod_w [8];
    logic signed [SW-1:0]  sum_w;
    logic                  s2_valid_q;
    logic                  s2_pass_q;
    logic signed [SW-1:0]  s2_sum_q;
    logic signed [SW-1:0]  rnd_w;
    logic signed [SW-1:0]  shr_w;
    logic [BIT_DEPTH-1:0]  res_w;
    logic                  out_valid_q;
    logic [BIT_DEPTH-1:0]  out_pixel_q;

    assign advance   = !(out_valid_q && !out_ready);
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;

    // A start-of-line sample empties the window so stale taps never leak across lines.
    always_comb begin
        for (int i = 0; i < 8; i++) win_d[i] = win_q[i];
        fill_d = fill_q;
        if (accept) begin
            if (in_sol) begin
                for (int i = 0; i < 7; i++) win_d[i] = '0;
                fill_d = 4'd1;
            end else begin
                for (int i = 0; i < 7; i++) win_d[i] = win_q[i+1];
                fill_d = (fill_q >= 4'd8) ? 4'd8 : fill_q + 4'd1;
            end
            win_d[7] = in_pixel;
        end
    end

    assign issue = accept && (fill_d == 4'd8);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 8; i++) win_q[i] <= '0;
            fill_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) win_q[i] <= win_d[i];
            fill_q <= fill_d;
            if (advance) begin
                s1_valid_q <= issue;
                if (issue) s1_phase_q <= in_phase;
            end
        end
    end

    // Stage 1 reads the live window: it only moves on an accept, which also moves stage 1.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_prod
            assign coef_w[gi] = (s1_phase_q == 2'd1) ? C1[gi] :
                                (s1_phase_q == 2'd2) ? C2[gi] :
                                (s1_phase_q == 2'd3) ? C3[gi] : 8'sd0;
            assign prod_w[gi] = $signed({{(SW-BIT_DEPTH){1'b0}}, win_q[gi]}) * SW'(coef_w[gi]);
        end
    endgenerate

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < 8; i++) sum_w = sum_w + prod_w[i];
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            s2_valid_q <= 1'b0;
            s2_pass_q  <= 1'b0;
            s2_sum_q   <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_pass_q <= (s1_phase_q == 2'd0);
                s2_sum_q  <= (s1_phase_q == 2'd0) ? $signed(SW'(win_q[3])) : sum_w;
            end
        end
    end

`ifdef HEVC_FIR_ROUND_EN
    assign rnd_w = s2_sum_q + SW'(32);
`else
    assign rnd_w = s2_sum_q;
`endif
    assign shr_w = rnd_w >>> 6;

    always_comb begin
        res_w = shr_w[BIT_DEPTH-1:0];
        if (s2_pass_q)                res_w = s2_sum_q[BIT_DEPTH-1:0];
        else if (shr_w < 0)           res_w = '0;
        else if (shr_w > PIX_MAX)     res_w = '1;
    end

    generate
        if (OUT_REG_STAGES == 3) begin : g_three
            logic                 s3_valid_q;
            logic [BIT_DEPTH-1:0] s3_pix_q;

            always_ff @(posedge clock or negedge reset_L) begin
                if (!reset_L) begin
                    s3_valid_q  <= 1'b0;
                    s3_pix_q    <= '0;
                    out_valid_q <= 1'b0;
                    out_pixel_q <= '0;
                end else if (advance) begin
                    s3_valid_q  <= s2_valid_q;
                    if (s2_valid_q) s3_pix_q <= res_w;
                    out_valid_q <= s3_valid_q;
                    if (s3_valid_q) out_pixel_q <= s3_pix_q;
                end
            end
        end else begin : g_two
            always_ff @(posedge clock or negedge reset_L) begin
                if (!reset_L) begin
                    out_valid_q <= 1'b0;
                    out_pixel_q <= '0;
                end else if (advance) begin
                    out_valid_q <= s2_valid_q;
                    if (s2_valid_q) out_pixel_q <= res_w;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_hevc_subpel_fir.sv
// Self-checking bench for hevc_subpel_fir: directed steps plus randomized lines,
// scored against a plain-arithmetic model of the interpolation filter.
module tb_hevc_subpel_fir;

    localparam int BD = 8;
    localparam int N  = 2;

    localparam int COEF [4][8] = '{
        '{0, 0, 0, 64, 0, 0, 0, 0},
        '{-1, 4, -10, 58, 17, -5, 1, 0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{0, 1, -5, 17, 58, -10, 4, -1}
    };

    logic          clock = 1'b0;
    logic          reset_L = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BD-1:0] in_pixel = '0;
    logic          in_sol = 1'b0;
    logic [1:0]    in_phase = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BD-1:0] out_pixel;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int last_pix = -1;
    int line_q [$];
    int exp_q  [$];

    hevc_subpel_fir #(.BIT_DEPTH(BD), .OUT_REG_STAGES(N)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_sol    (in_sol),
        .in_phase  (in_phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int model_px(input int t [8], input int ph);
        int s;
        if (ph == 0) return t[3];
        s = 0;
        for (int i = 0; i < 8; i++) s += COEF[ph][i] * t[i];
`ifdef HEVC_FIR_ROUND_EN
        s += 32;
`endif
        s = s >>> 6;
        if (s < 0) s = 0;
        if (s > (1 << BD) - 1) s = (1 << BD) - 1;
        return s;
    endfunction

    // Scoreboard: inputs and outputs are both observed on the falling edge.
    always @(negedge clock) begin
        int taps [8];
        int e;
        if (!reset_L) begin
            line_q.delete();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out %0d pixel=%0d expected=%0d", n_out, out_pixel, e);
                    check("out_pixel", 32'(out_pixel), e);
                    last_pix = int'(out_pixel);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                if (in_sol) line_q.delete();
                line_q.push_back(int'(in_pixel));
                if (line_q.size() > 8) void'(line_q.pop_front());
                if (line_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) taps[i] = line_q[i];
                    exp_q.push_back(model_px(taps, int'(in_phase)));
                end
            end
        end
    end

    task automatic send(input int pix, input logic sol, input int ph, input bit bp);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_pixel = BD'(pix);
        in_sol   = sol;
        in_phase = 2'(ph);
        while (1) begin
            if (bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
            guard++;
            if (guard > 100) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic drain(input int cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic send_line(input int px [8], input int last_ph);
        for (int i = 0; i < 8; i++)
            send(px[i], i == 0, (i == 7) ? last_ph : int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        int px [8];
        int held;
        int n0;
        int len;

        #2 reset_L = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_pixel", 32'(out_pixel), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        #19 reset_L = 1'b1;
        @(posedge clock); #1;

        // Constant 100 line: exact latency, then one output per further sample.
        for (int i = 0; i < 8; i++) send(100, i == 0, 2, 1'b0);
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clock);
            check("latency_valid", 32'(out_valid), 32'(k == N + 1));
        end
        check("const_pixel", 32'(out_pixel), 100);
        @(posedge clock); #1;
        n0 = n_out;
        for (int i = 0; i < 3; i++) send(100, 1'b0, 2, 1'b0);
        drain(N + 2);
        check("const_followers", n_out - n0, 3);
        check("const_last", last_pix, 100);

        // Clipping at both ends.
        px = '{0, 0, 0, 255, 255, 0, 0, 0};
        send_line(px, 2); drain(N + 2);
        check("clip_high", last_pix, 255);
        px = '{255, 255, 255, 0, 0, 255, 255, 255};
        send_line(px, 2); drain(N + 2);
        check("clip_low", last_pix, 0);

        // Rounding behaviour of a sum of 40.
        px = '{0, 0, 0, 1, 0, 0, 0, 0};
        send_line(px, 2); drain(N + 2);
`ifdef HEVC_FIR_ROUND_EN
        check("round_sum40", last_pix, 1);
`else
        check("round_sum40", last_pix, 0);
`endif

        // Phase of the issuing sample selects the filter.
        px = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_line(px, 0); drain(N + 2);
        check("phase0", last_pix, 40);
        send_line(px, 1); drain(N + 2);
        check("phase1", last_pix, 42);

        // Backpressure with a continuous stream.
        for (int i = 0; i < 10; i++) send($urandom_range(0, 255), i == 0, $urandom_range(0, 3), 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = BD'($urandom_range(0, 255));
        in_phase  = 2'($urandom_range(0, 3));
        @(negedge clock);
        held = int'(out_pixel);
        check("stall_out_valid", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_hold", 32'(out_pixel), held);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("release_b2b", 32'(out_valid && in_ready), 1);
            @(posedge clock); #1;
            in_pixel = BD'($urandom_range(0, 255));
            in_phase = 2'($urandom_range(0, 3));
        end
        drain(N + 2);

        // Start of line after 5 samples: nothing until 8 fresh samples.
        n0 = n_out;
        for (int i = 0; i < 5; i++) send($urandom_range(0, 255), i == 0, $urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 7; i++) send($urandom_range(0, 255), i == 0, $urandom_range(0, 3), 1'b0);
        drain(N + 2);
        check("sol_no_output", n_out - n0, 0);
        send($urandom_range(0, 255), 1'b0, $urandom_range(0, 3), 1'b0);
        drain(N + 2);
        check("sol_eighth", n_out - n0, 1);

        // Reset mid-stream: immediate clear, then implicit start of line.
        for (int i = 0; i < 10; i++) send($urandom_range(0, 255), i == 0, $urandom_range(0, 3), 1'b0);
        check("pre_reset_valid", 32'(out_valid), 1);
        #2 reset_L = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 0);
        check("async_reset_pixel", 32'(out_pixel), 0);
        @(negedge clock);
        #2 reset_L = 1'b1;
        @(posedge clock); #1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 255), 1'b0, $urandom_range(0, 3), 1'b0);
        drain(N + 2);
        check("post_reset_line", n_out - n0, 1);

        // Randomized lines with random backpressure and mid-flight line starts.
        for (int l = 0; l < 8; l++) begin
            len = $urandom_range(5, 20);
            for (int i = 0; i < len; i++)
                send($urandom_range(0, 255), i == 0, $urandom_range(0, 3), 1'b1);
        end
        drain(N + 4);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hevc_subpel_fir.md
HEVC_SUBPEL_FIR -- requirements
Module: hevc_subpel_fir

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, sample width in bits (legal 8..12).
REQ-002 SHALL have parameter OUT_REG_STAGES, default 2, pipeline depth from accept to out_valid (legal 2 or 3).
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_pixel, in_sol and in_phase are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-007 SHALL have port in_pixel, input, BIT_DEPTH bits: unsigned integer sample, raster order.
REQ-008 SHALL have port in_sol, input, 1 bit: sample is the first of a line.
REQ-009 SHALL have port in_phase, input, 2 bits: 0 full, 1 quarter, 2 half, 3 three-quarter.
REQ-010 SHALL have port out_valid, output, 1 bit: out_pixel is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes out_pixel.
REQ-012 SHALL have port out_pixel, output, BIT_DEPTH bits: filtered and clipped sub-pixel.

Function
REQ-013 SHALL accept a sample when in_valid and in_ready are both 1 at a rising edge.
REQ-014 SHALL keep an 8-entry window, tap0 oldest through tap7 newest; each accepted sample shifts in at tap7.
REQ-015 SHALL keep a fill count of 0..8 that saturates at 8.
REQ-016 SHALL, on an accepted sample with in_sol=1, discard the prior window contents and set the fill count to 1.
REQ-017 SHALL issue a filter operation only for an accepted sample that makes the fill count 8; no output is produced for the first 7 samples of a line.
REQ-018 SHALL use the in_phase value captured with the sample that issues the operation.
REQ-019 SHALL select coefficients tap0..tap7 by phase:
- phase 0: tap3 is passed through unchanged (no arithmetic).
- phase 1: -1,4,-10,58,17,-5,1,0.
- phase 2: -1,4,-11,40,40,-11,4,-1.
- phase 3: 0,1,-5,17,58,-10,4,-1.
REQ-020 SHALL form the signed sum at BIT_DEPTH+9 bits with no overflow.
REQ-021 SHALL form the result as an arithmetic right shift of the sum by 6, with the rounding of REQ-031/032.
REQ-022 SHALL clip the result to the range 0..2^BIT_DEPTH-1, at both ends.
REQ-023 SHALL be a stall-able pipeline of OUT_REG_STAGES stages; out_valid rises OUT_REG_STAGES cycles after the issuing accept when there is no stall.
REQ-024 SHALL define advance = !(out_valid && !out_ready), and SHALL drive in_ready = advance (combinational).
REQ-025 SHALL NOT shift any stage while advance=0.
REQ-026 SHALL hold out_pixel and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL let bubbles (invalid stages) advance; throughput SHALL be one output per cycle when out_ready is held at 1.
REQ-028 SHALL still deliver operations already in flight when in_sol arrives; in_sol affects only the window.

Reset
REQ-029 SHALL, while reset_L=0, immediately clear the following regardless of clock: out_valid=0, out_pixel=0, all stage valids, fill count=0, window=0.
REQ-030 SHALL, on reset asserted mid-line or mid-stall, lose all in-flight data; the first accepted sample after release is treated as start of line whether or not in_sol=1.

Configuration
REQ-031 SHALL, with macro HEVC_FIR_ROUND_EN defined, compute the result as (sum+32)>>>6 (round half up).
REQ-032 SHALL, with HEVC_FIR_ROUND_EN undefined, compute the result as sum>>>6 (floor); latency and handshake SHALL be identical in both builds.

Verification
REQ-033 Constant: BIT_DEPTH=8, 8 samples of 100, phase 2 -> exactly one out_pixel=100, OUT_REG_STAGES cycles after the 8th accept; then 100 per further sample.
REQ-034 Clip high and low, phase 2:
- window 0,0,0,255,255,0,0,0 -> out_pixel=255.
- window 255,255,255,0,0,255,255,255 -> out_pixel=0.
REQ-035 Rounding: window with tap3=1, all other taps 0, phase 2 (sum 40) -> out_pixel=1 with HEVC_FIR_ROUND_EN, 0 without.
REQ-036 Phases: window 10,20,...,80, phase 0 -> 40; phase 1 -> 42 (rounded).
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_pixel stable, no sample lost; release -> outputs in order, back to back.
REQ-038 in_sol after 5 samples, then 8 more samples -> no output until the 8th new sample; reset_L pulse mid-stream -> out_valid=0 immediately.
